// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the OV7670 pixel capture path
package cam_pkg;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    FRAME      = 1'b1
  } cap_state_t;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } byte_phase_t;

  localparam int DEF_WIN_W    = 250;
  localparam int DEF_WIN_H    = 250;
  localparam int DEF_LINE_PX  = 640;
  localparam int DEF_FRAME_LN = 480;

  localparam int GRAY_KR = 77;
  localparam int GRAY_KG = 150;
  localparam int GRAY_KB = 29;

  localparam logic [9:0] X_MAX = 10'd1023;
  localparam logic [8:0] Y_MAX = 9'd511;

endpackage

// File: rtl/rgb565_to_gray.sv
// rtl/rgb565_to_gray.sv - combinational RGB565 to 8-bit luma, built only with GRAY_OUT_EN
`ifdef GRAY_OUT_EN
module rgb565_to_gray
  import cam_pkg::*;
(
  input  logic [15:0] pix,
  output logic [7:0]  gray
);

  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [15:0] acc;

  // Channels are widened by bit replication so full-scale 565 maps to 255.
  always_comb begin
    r8   = {pix[15:11], pix[15:13]};
    g8   = {pix[10:5], pix[10:9]};
    b8   = {pix[4:0], pix[4:2]};
    acc  = 16'(GRAY_KR) * {8'd0, r8} + 16'(GRAY_KG) * {8'd0, g8} + 16'(GRAY_KB) * {8'd0, b8};
    gray = 8'(acc >> 8);
  end

endmodule
`endif

// File: rtl/cam_pixel_capture.sv
// rtl/cam_pixel_capture.sv - OV7670 DVP capture: byte pairing, x/y tracking, window crop, error flags
// Defining GRAY_OUT_EN adds the registered gray output.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int WIN_W    = DEF_WIN_W,
  parameter int WIN_H    = DEF_WIN_H,
  parameter int LINE_PX  = DEF_LINE_PX,
  parameter int FRAME_LN = DEF_FRAME_LN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  data_wires,
  output logic        p_valid,
  output logic [15:0] p_data,
  output logic        w_en,
  output logic [7:0]  w_addr_c,
  output logic [7:0]  w_addr_r,
  output logic [9:0]  x_pos,
  output logic [8:0]  y_pos,
  output logic        f_done,
  output logic        line_err,
  output logic        frame_err
`ifdef GRAY_OUT_EN
  ,
  output logic [7:0]  gray
`endif
);

  localparam logic [9:0] WIN_W_V    = 10'(WIN_W);
  localparam logic [8:0] WIN_H_V    = 9'(WIN_H);
  localparam logic [9:0] LINE_PX_V  = 10'(LINE_PX);
  localparam logic [8:0] FRAME_LN_V = 9'(FRAME_LN);

  logic        vs_r, hr_r, vs_q, hr_q;
  logic [7:0]  d_r;
  cap_state_t  state, state_nx;
  byte_phase_t phase;
  logic [9:0]  x_cnt;
  logic [8:0]  y_cnt, y_closed;
  logic        vs_rise, vs_fall, frame_start, frame_end;
  logic        byte_ok, pix_emit, line_end, line_bad, in_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_r <= 1'b0;
      hr_r <= 1'b0;
      vs_q <= 1'b0;
      hr_q <= 1'b0;
      d_r  <= 8'd0;
    end else begin
      vs_r <= vsync;
      hr_r <= href;
      vs_q <= vs_r;
      hr_q <= hr_r;
      d_r  <= data_wires;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_FRAME;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_FRAME: if (vs_fall) state_nx = FRAME;
      FRAME:      if (vs_rise) state_nx = WAIT_FRAME;
      default:    state_nx = WAIT_FRAME;
    endcase
  end

  // A vsync rise with href still high closes the truncated line in the same cycle.
  always_comb begin
    vs_rise     = vs_r & ~vs_q;
    vs_fall     = ~vs_r & vs_q;
    frame_start = (state == WAIT_FRAME) & vs_fall;
    frame_end   = (state == FRAME) & vs_rise;
    byte_ok     = (state == FRAME) & hr_r & ~vs_rise;
    pix_emit    = byte_ok & (phase == PH_LO);
    line_end    = (state == FRAME) & ((hr_q & ~hr_r) | (vs_rise & hr_r));
    line_bad    = (phase == PH_LO) | (x_cnt != LINE_PX_V) | (vs_rise & hr_r);
    in_win      = (x_cnt < WIN_W_V) & (y_cnt < WIN_H_V);
    y_closed    = y_cnt;
    if (line_end && (x_cnt != 10'd0) && (y_cnt != Y_MAX)) y_closed = y_cnt + 9'd1;
  end

`ifdef GRAY_OUT_EN
  logic [7:0] gray_c;

  rgb565_to_gray u_gray (
    .pix  ({p_data[15:8], d_r}),
    .gray (gray_c)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid   <= 1'b0;
      p_data    <= 16'd0;
      w_en      <= 1'b0;
      w_addr_c  <= 8'd0;
      w_addr_r  <= 8'd0;
      x_pos     <= 10'd0;
      f_done    <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      phase     <= PH_HI;
      x_cnt     <= 10'd0;
      y_cnt     <= 9'd0;
`ifdef GRAY_OUT_EN
      gray      <= 8'd0;
`endif
    end else begin
      p_valid <= pix_emit;
      w_en    <= pix_emit & in_win;
      f_done  <= frame_end;
      if (frame_start) begin
        line_err  <= 1'b0;
        frame_err <= 1'b0;
      end
      if (byte_ok) begin
        if (phase == PH_HI) begin
          p_data[15:8] <= d_r;
          phase        <= PH_LO;
        end else begin
          p_data[7:0] <= d_r;
          phase       <= PH_HI;
          x_pos       <= x_cnt;
          w_addr_c    <= x_cnt[7:0];
          w_addr_r    <= y_cnt[7:0];
          if (x_cnt != X_MAX) x_cnt <= x_cnt + 10'd1;
`ifdef GRAY_OUT_EN
          gray        <= gray_c;
`endif
        end
      end
      if (line_end) begin
        x_cnt <= 10'd0;
        phase <= PH_HI;
        y_cnt <= y_closed;
        if (line_bad) line_err <= 1'b1;
      end
      if (frame_end) begin
        x_cnt <= 10'd0;
        y_cnt <= 9'd0;
        if (y_closed != FRAME_LN_V) frame_err <= 1'b1;
      end
    end
  end

  assign y_pos = y_cnt;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb/tb_cam_pixel_capture.sv - scoreboard bench for cam_pixel_capture (GRAY_OUT_EN checked when defined)
module tb_cam_pixel_capture;

  localparam int WIN_W    = 10;
  localparam int WIN_H    = 8;
  localparam int LINE_PX  = 16;
  localparam int FRAME_LN = 12;

  logic        clk = 1'b0;
  logic        rst, vsync, href;
  logic [7:0]  data_wires;
  logic        p_valid, w_en, f_done, line_err, frame_err;
  logic [15:0] p_data;
  logic [7:0]  w_addr_c, w_addr_r;
  logic [9:0]  x_pos;
  logic [8:0]  y_pos;
`ifdef GRAY_OUT_EN
  logic [7:0]  gray;
`endif

  always #5 clk = ~clk;

  cam_pixel_capture #(
    .WIN_W    (WIN_W),
    .WIN_H    (WIN_H),
    .LINE_PX  (LINE_PX),
    .FRAME_LN (FRAME_LN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .href       (href),
    .data_wires (data_wires),
    .p_valid    (p_valid),
    .p_data     (p_data),
    .w_en       (w_en),
    .w_addr_c   (w_addr_c),
    .w_addr_r   (w_addr_r),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .f_done     (f_done),
    .line_err   (line_err),
    .frame_err  (frame_err)
`ifdef GRAY_OUT_EN
    ,
    .gray       (gray)
`endif
  );

  typedef struct {
    logic [15:0] data;
    logic        wen;
    logic [9:0]  x;
    logic [8:0]  y;
  } pix_t;

  typedef struct {
    logic lerr;
    logic ferr;
  } frm_t;

  pix_t       exp_pix[$];
  frm_t       exp_frm[$];
  int         lens[$];
  logic [7:0] fixed_bytes[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         wen_cnt = 0;
  int         pv_cnt = 0;
  logic [7:0] last_c = 8'd0;
  logic [7:0] last_r = 8'd0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

`ifdef GRAY_OUT_EN
  function automatic logic [7:0] gray_ref(input logic [15:0] p);
    logic [7:0] r8, g8, b8;
    r8 = {p[15:11], p[15:13]};
    g8 = {p[10:5], p[10:9]};
    b8 = {p[4:0], p[4:2]};
    return 8'((77 * int'(r8) + 150 * int'(g8) + 29 * int'(b8)) / 256);
  endfunction
`endif

  always @(negedge clk) begin
    pix_t e;
    frm_t f;
    if (w_en && !p_valid) check("w_en_without_p_valid", 32'(w_en), 32'(0));
    if (p_valid) begin
      pv_cnt++;
      if (exp_pix.size() == 0) begin
        check("unexpected_pixel", 32'(p_valid), 32'(0));
      end else begin
        e = exp_pix.pop_front();
        check("p_data", 32'(p_data), 32'(e.data));
        check("w_en", 32'(w_en), 32'(e.wen));
        check("x_pos", 32'(x_pos), 32'(e.x));
        check("y_pos", 32'(y_pos), 32'(e.y));
        if (e.wen) begin
          check("w_addr_c", 32'(w_addr_c), 32'(e.x[7:0]));
          check("w_addr_r", 32'(w_addr_r), 32'(e.y[7:0]));
        end
`ifdef GRAY_OUT_EN
        check("gray", 32'(gray), 32'(gray_ref(e.data)));
`endif
      end
      if (w_en) begin
        wen_cnt++;
        last_c = w_addr_c;
        last_r = w_addr_r;
      end
    end
    if (f_done) begin
      if (exp_frm.size() == 0) begin
        check("unexpected_f_done", 32'(f_done), 32'(0));
      end else begin
        f = exp_frm.pop_front();
        check("line_err_at_f_done", 32'(line_err), 32'(f.lerr));
        check("frame_err_at_f_done", 32'(frame_err), 32'(f.ferr));
      end
    end
  end

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    vsync      = v;
    href       = h;
    data_wires = d;
    @(negedge clk);
  endtask

  task automatic junk(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  // Reference model: a frame is a list of line byte counts; pixels pair bytes in order.
  task automatic run_frame(input bit trunc, input bit glue);
    logic [7:0] all_b[$];
    pix_t e;
    int   idx, y, n, px;
    bit   lerr;
    for (int i = 0; i < lens.size(); i++)
      for (int b = 0; b < lens[i]; b++)
        all_b.push_back(fixed_bytes.size() != 0 ? fixed_bytes.pop_front() : 8'($urandom));
    idx  = 0;
    y    = 0;
    lerr = 1'b0;
    for (int i = 0; i < lens.size(); i++) begin
      n  = lens[i];
      px = n / 2;
      for (int p = 0; p < px; p++) begin
        e.data = {all_b[idx + 2 * p], all_b[idx + 2 * p + 1]};
        e.wen  = (p < WIN_W) && (y < WIN_H);
        e.x    = 10'(p);
        e.y    = 9'(y);
        exp_pix.push_back(e);
      end
      if ((n % 2) != 0 || px != LINE_PX || (trunc && i == lens.size() - 1)) lerr = 1'b1;
      if (px > 0 && y < 511) y++;
      idx += n;
    end
    exp_frm.push_back('{lerr, (y != FRAME_LN)});

    repeat (3) drive(1'b1, 1'b0, 8'($urandom));
    repeat (2) drive(1'b0, 1'b0, 8'($urandom));
    check("line_err_clear_at_start", 32'(line_err), 32'(0));
    check("frame_err_clear_at_start", 32'(frame_err), 32'(0));
    idx = 0;
    for (int i = 0; i < lens.size(); i++) begin
      for (int b = 0; b < lens[i]; b++) begin
        drive(1'b0, 1'b1, all_b[idx]);
        idx++;
      end
      if (i != lens.size() - 1 || (!trunc && !glue))
        repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0, 8'($urandom));
    end
    if (trunc) drive(1'b1, 1'b1, 8'($urandom));
    repeat (3) drive(1'b1, 1'b0, 8'($urandom));
    check("pixels_pending_after_frame", 32'(exp_pix.size()), 32'(0));
    check("frames_pending_after_frame", 32'(exp_frm.size()), 32'(0));
  endtask

  task automatic full_lens();
    lens.delete();
    for (int i = 0; i < FRAME_LN; i++) lens.push_back(2 * LINE_PX);
  endtask

  initial begin
    pix_t e;
    rst = 1'b1;
    vsync = 1'b0;
    href = 1'b0;
    data_wires = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_p_valid", 32'(p_valid), 32'(0));
    check("rst_w_en", 32'(w_en), 32'(0));
    check("rst_p_data", 32'(p_data), 32'(0));
    check("rst_xy", 32'({x_pos, y_pos}), 32'(0));
    check("rst_flags", 32'({f_done, line_err, frame_err}), 32'(0));
    rst = 1'b0;

    junk(40);
    check("no_pixels_before_first_frame", 32'(pv_cnt), 32'(0));

    lens = {4};
    fixed_bytes = {8'hF8, 8'h00, 8'h07, 8'hE0};
    wen_cnt = 0;
    run_frame(1'b0, 1'b0);
    check("short_line_w_en_count", 32'(wen_cnt), 32'(2));

    full_lens();
    wen_cnt = 0;
    run_frame(1'b0, 1'b1);
    check("full_frame_w_en_count", 32'(wen_cnt), 32'(WIN_W * WIN_H));
    check("full_frame_last_col", 32'(last_c), 32'(WIN_W - 1));
    check("full_frame_last_row", 32'(last_r), 32'(WIN_H - 1));

    lens = {2 * LINE_PX, 3, 2 * LINE_PX};
    fixed_bytes = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'hF8, 8'h00};
    run_frame(1'b0, 1'b0);

    for (int f = 0; f < 8; f++) begin
      lens.delete();
      for (int i = 0; i < FRAME_LN - 1 + $urandom_range(0, 2); i++)
        lens.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 2 * LINE_PX);
      run_frame(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0));
    end

    // Reset in the middle of line 1, just after pixel 5 and one dangling HI byte.
    repeat (3) drive(1'b1, 1'b0, 8'($urandom));
    repeat (2) drive(1'b0, 1'b0, 8'($urandom));
    for (int p = 0; p < LINE_PX; p++) begin
      e.data = 16'($urandom);
      e.wen  = (p < WIN_W);
      e.x    = 10'(p);
      e.y    = 9'd0;
      exp_pix.push_back(e);
      drive(1'b0, 1'b1, e.data[15:8]);
      drive(1'b0, 1'b1, e.data[7:0]);
    end
    repeat (2) drive(1'b0, 1'b0, 8'($urandom));
    for (int p = 0; p < 6; p++) begin
      e.data = 16'($urandom);
      e.wen  = 1'b1;
      e.x    = 10'(p);
      e.y    = 9'd1;
      exp_pix.push_back(e);
      drive(1'b0, 1'b1, e.data[15:8]);
      drive(1'b0, 1'b1, e.data[7:0]);
    end
    drive(1'b0, 1'b1, 8'($urandom));
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'($urandom));
    rst = 1'b0;
    check("mid_line_rst_p_valid", 32'(p_valid), 32'(0));
    check("mid_line_rst_w_en", 32'(w_en), 32'(0));
    check("mid_line_rst_xy", 32'({x_pos, y_pos}), 32'(0));
    check("mid_line_rst_pending", 32'(exp_pix.size()), 32'(0));
    pv_cnt = 0;
    junk(60);
    check("no_pixels_after_mid_line_rst", 32'(pv_cnt), 32'(0));

    full_lens();
    wen_cnt = 0;
    run_frame(1'b0, 1'b0);
    check("recovered_frame_w_en_count", 32'(wen_cnt), 32'(WIN_W * WIN_H));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
